// File: rtl/kamus_l1d.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one-word lines.
// Loads hit combinationally; misses refill over a req/gnt/rvalid bus, stores always write through.
module kamus_l1d #(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        l1d_req_i,
    input  logic        l1d_wr_en_i,
    input  logic [3:0]  l1d_be_i,
    input  logic [31:0] l1d_addr_i,
    input  logic [31:0] l1d_wr_data_i,
    output logic [31:0] l1d_rd_data_o,
    output logic        l1d_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int TAG_W = 30 - IDX_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_DONE = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES];

    // Transaction copy taken in IDLE, so a dropped l1d_req_i cannot disturb an in-flight access.
    logic [31:2]          txn_addr_q;
    logic [3:0]           txn_be_q;
    logic [31:0]          txn_wdata_q;

    logic [IDX_W-1:0]     idx, txn_idx;
    logic [TAG_W-1:0]     tag, txn_tag;
    logic                 hit, txn_hit;
    logic                 unused_addr_lsb;

    assign idx     = l1d_addr_i[IDX_W+1:2];
    assign tag     = l1d_addr_i[31:IDX_W+2];
    assign txn_idx = txn_addr_q[IDX_W+1:2];
    assign txn_tag = txn_addr_q[31:IDX_W+2];
    assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
    assign txn_hit = valid_q[txn_idx] && (tag_mem[txn_idx] == txn_tag);

    assign unused_addr_lsb = ^l1d_addr_i[1:0];

    assign l1d_rd_data_o = data_mem[idx];
    assign mem_addr_o    = {txn_addr_q, 2'b00};
    assign mem_be_o      = (state_q == S_WR_REQ) ? txn_be_q : 4'hF;
    assign mem_wdata_o   = txn_wdata_q;

    always_comb begin
        state_d     = state_q;
        l1d_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (l1d_req_i) begin
                    if (l1d_wr_en_i) begin
                        l1d_stall_o = 1'b1;
                        state_d     = S_WR_REQ;
                    end else if (!hit) begin
                        l1d_stall_o = 1'b1;
                        state_d     = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                l1d_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                if (mem_gnt_i) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                l1d_stall_o = 1'b1;
                if (mem_rvalid_i) state_d = S_IDLE;
            end
            S_WR_REQ: begin
                l1d_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                if (mem_gnt_i) state_d = S_WR_DONE;
            end
            // Store retires here; whatever request is visible this cycle is the one just done.
            S_WR_DONE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_RD_WAIT && mem_rvalid_i) valid_q[txn_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE) begin
            txn_addr_q  <= l1d_addr_i[31:2];
            txn_be_q    <= l1d_be_i;
            txn_wdata_q <= l1d_wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_RD_WAIT && mem_rvalid_i) begin
                data_mem[txn_idx] <= mem_rdata_i;
                tag_mem[txn_idx]  <= txn_tag;
            end else if (state_q == S_WR_REQ && mem_gnt_i && txn_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (txn_be_q[b]) data_mem[txn_idx][8*b +: 8] <= txn_wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_kamus_l1d.sv
// Randomized bench for kamus_l1d: a line/memory reference model plus a bus responder with
// chosen gnt/rvalid delays; stall length, bus fields and load data are predicted per access.
module tb_kamus_l1d;

    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        l1d_req_i = 1'b0;
    logic        l1d_wr_en_i = 1'b0;
    logic [3:0]  l1d_be_i = 4'h0;
    logic [31:0] l1d_addr_i = '0;
    logic [31:0] l1d_wr_data_i = '0;
    logic [31:0] l1d_rd_data_o;
    logic        l1d_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int total = 0;
    int bad = 0;

    // reference model: cache lines and backing memory
    bit          m_valid [NL];
    int          m_tag   [NL];
    logic [31:0] m_data  [NL];
    logic [31:0] mem     [int];

    kamus_l1d #(.NUM_LINES(NL)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .l1d_req_i(l1d_req_i), .l1d_wr_en_i(l1d_wr_en_i), .l1d_be_i(l1d_be_i),
        .l1d_addr_i(l1d_addr_i), .l1d_wr_data_i(l1d_wr_data_i),
        .l1d_rd_data_o(l1d_rd_data_o), .l1d_stall_o(l1d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input int w);
        logic [31:0] wv;
        wv = 32'(w);
        if (mem.exists(w)) return mem[w];
        return (wv * 32'h0100_0193) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        l1d_req_i = 1'b0;
        #1;
        chk({tag, "_stall"}, {31'd0, l1d_stall_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
    endtask

    // Called just after a negedge; returns just after a negedge with the cache idle.
    task automatic access(input bit wr, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rd);
        int w, idx, tg, exp_stall, stalls, reqc, waitc;
        bit mhit, granted, done;
        logic [31:0] exp_data;
        w = int'(addr >> 2);
        idx = w % NL;
        tg = w / NL;
        mhit = m_valid[idx] && (m_tag[idx] == tg);
        exp_stall = wr ? 2 + gd : (mhit ? 0 : 3 + gd + rd);
        exp_data = mhit ? m_data[idx] : memrd(w);
        stalls = 0; reqc = 0; waitc = 0; granted = 0; done = 0;
        l1d_req_i = 1'b1; l1d_wr_en_i = wr; l1d_be_i = be;
        l1d_addr_i = addr; l1d_wr_data_i = wd;
        while (!done) begin
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i = $urandom;
            #1;
            if (!l1d_stall_o) begin
                done = 1;
                chk("done_req", {31'd0, mem_req_o}, 32'd0);
                if (!wr) chk("rd_data", l1d_rd_data_o, exp_data);
            end else begin
                stalls++;
                if (mem_req_o) begin
                    if (granted) chk("req_after_gnt", 32'd1, 32'd0);
                    reqc++;
                    chk("mem_addr", mem_addr_o, {addr[31:2], 2'b00});
                    chk("mem_we", {31'd0, mem_we_o}, {31'd0, wr});
                    chk("mem_be", {28'd0, mem_be_o}, {28'd0, (wr ? be : 4'hF)});
                    if (wr) chk("mem_wdata", mem_wdata_o, wd);
                    if (reqc - 1 == gd) begin
                        mem_gnt_i = 1'b1;
                        granted = 1;
                    end
                end else if (granted && !wr) begin
                    waitc++;
                    if (waitc - 1 == rd) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i = memrd(w);
                    end
                end
                if (stalls > 100) begin
                    chk("timeout", 32'd1, 32'd0);
                    done = 1;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        chk(wr ? "st_stalls" : "ld_stalls", 32'(stalls), 32'(exp_stall));
        if (wr) begin
            mem[w] = merge(memrd(w), wd, be);
            if (mhit) m_data[idx] = merge(m_data[idx], wd, be);
        end else if (!mhit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
            m_data[idx] = memrd(w);
        end
        @(posedge clk);
        @(negedge clk);
        idle_check("after");
    endtask

    initial begin
        model_clear();
        mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_stall", {31'd0, l1d_stall_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        // directed scenarios
        access(0, 4'hF, 32'h100, 32'h0, 0, 0);
        access(0, 4'hF, 32'h100, 32'h0, 0, 0);
        access(1, 4'b0011, 32'h100, 32'h0000_CAFE, 1, 0);
        access(0, 4'hF, 32'h100, 32'h0, 0, 0);
        chk("cafe_merge", m_data[0], 32'hDEAD_CAFE);
        access(1, 4'hF, 32'h200, 32'h1111_2222, 0, 0);
        access(0, 4'hF, 32'h200, 32'h0, 0, 1);
        access(0, 4'hF, 32'h100 + 4 * NL, 32'h0, 2, 0);
        access(0, 4'hF, 32'h100, 32'h0, 0, 2);
        access(1, 4'h0, 32'h100, 32'hFFFF_FFFF, 0, 0);
        access(0, 4'hF, 32'h100, 32'h0, 0, 0);
        access(0, 4'hF, 32'h180, 32'h0, 10, 0);

        // reset while waiting for rvalid; the late rvalid must not install anything
        l1d_req_i = 1'b1; l1d_wr_en_i = 1'b0; l1d_addr_i = 32'h300;
        #1;
        chk("rw_idle_stall", {31'd0, l1d_stall_o}, 32'd1);
        @(posedge clk); @(negedge clk);
        #1;
        chk("rw_rdreq", {31'd0, mem_req_o}, 32'd1);
        mem_gnt_i = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt_i = 1'b0;
        #1;
        chk("rw_wait_req", {31'd0, mem_req_o}, 32'd0);
        chk("rw_wait_stall", {31'd0, l1d_stall_o}, 32'd1);
        rst_i = 1'b1;
        l1d_req_i = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        #1;
        chk("rw_post_req", {31'd0, mem_req_o}, 32'd0);
        chk("rw_post_stall", {31'd0, l1d_stall_o}, 32'd0);
        @(posedge clk); @(negedge clk);
        mem_rvalid_i = 1'b0;
        idle_check("rw_idle");
        model_clear();
        access(0, 4'hF, 32'h300, 32'h0, 0, 0);
        access(0, 4'hF, 32'h100, 32'h0, 0, 0);

        // randomized traffic over a few tags so hits, misses and conflicts all occur
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            int tg, ix;
            tg = $urandom_range(0, 2) + 4;
            ix = $urandom_range(0, NL - 1);
            a = (32'(tg * NL + ix) << 2) | 32'($urandom_range(0, 3));
            access(($urandom_range(0, 9) < 4), 4'($urandom), a, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); @(negedge clk);
                idle_check("gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
